color_scan_engine: RTL and testbench

//  Parametrised successor to the fixed 4-sensor selector/detector pair. Sequences NUM_SENSORS TCS3200 sensors over a

---
 rtl/color_scan_engine.sv | 199 +++++++++++++++++++
 tb/tb_color_scan_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/color_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : color_scan_engine
// Brief    : Sequences NUM_SENSORS colour sensors on a shared frequency line,
//            measures R/G/B/C per sensor, classifies to RGBY and streams results.
// Revision : 1.0  initial release
// ============================================================================
module color_scan_engine #(
   parameter int NUM_SENSORS   = 4,
   parameter int SEL_W         = 2,
   parameter int COUNT_W       = 12,
   parameter int GATE_CYCLES   = 1000,
   parameter int SETTLE_CYCLES = 50,
   parameter int YEL_SHIFT     = 2,
   parameter int MIN_CLEAR     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic                   i_freq_in,
   output logic [NUM_SENSORS-1:0] o_sensor_sel,
   output logic [1:0]             o_color_sel,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [1:0]             o_out_color,
   output logic [SEL_W-1:0]       o_out_index,
   output logic                   o_out_dark,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0]   c_GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   c_SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] c_CNT_MAX     = '1;
   localparam logic [COUNT_W-1:0] c_MIN_CLEAR   = COUNT_W'(MIN_CLEAR);
   localparam logic [SEL_W-1:0]   c_LAST_IDX    = SEL_W'(NUM_SENSORS - 1);

   localparam logic [2:0] c_ST_IDLE     = 3'd0;
   localparam logic [2:0] c_ST_SETTLE   = 3'd1;
   localparam logic [2:0] c_ST_GATE     = 3'd2;
   localparam logic [2:0] c_ST_CLASSIFY = 3'd3;
   localparam logic [2:0] c_ST_EMIT     = 3'd4;

   // Filter slots in measurement order: 0=R 1=G 2=B 3=C
   localparam logic [1:0] c_F_CLEAR = 2'd3;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [TMR_W-1:0]   r_tmr;
   logic [1:0]         r_filt;
   logic [SEL_W-1:0]   r_idx;
   logic [1:0]         r_sync;
   logic               r_prev;
   logic [COUNT_W-1:0] r_cnt;
   logic [COUNT_W-1:0] r_meas [4];
   logic [1:0]         r_color;
   logic [SEL_W-1:0]   r_out_index;
   logic               r_dark;
   logic               r_done;

   logic               w_rise;
   logic [COUNT_W-1:0] w_cnt_nxt;
   logic               w_settle_last;
   logic               w_gate_last;
   logic               w_accept;
   logic               w_last_sensor;
   logic [COUNT_W-1:0] w_r;
   logic [COUNT_W-1:0] w_g;
   logic [COUNT_W-1:0] w_b;
   logic [COUNT_W-1:0] w_rg_max;
   logic [COUNT_W-1:0] w_rg_diff;
   logic [1:0]         w_class;

   assign w_rise        = r_sync[1] & ~r_prev;
   assign w_cnt_nxt     = (w_rise && (r_cnt != c_CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
   assign w_settle_last = (r_tmr == c_SETTLE_LAST);
   assign w_gate_last   = (r_tmr == c_GATE_LAST);
   assign w_accept      = (r_state == c_ST_EMIT) && i_out_ready;
   assign w_last_sensor = (r_idx == c_LAST_IDX);

   assign w_r       = r_meas[0];
   assign w_g       = r_meas[1];
   assign w_b       = r_meas[2];
   assign w_rg_max  = (w_r > w_g) ? w_r : w_g;
   assign w_rg_diff = (w_r >= w_g) ? (w_r - w_g) : (w_g - w_r);

   // Yellow test first; otherwise the largest channel wins, ties favour red then green
   always_comb begin
      w_class = 2'd2;
      if ((w_r > w_b) && (w_g > w_b) && (w_rg_diff <= (w_rg_max >> YEL_SHIFT)))
         w_class = 2'd3;
      else if ((w_r >= w_g) && (w_r >= w_b))
         w_class = 2'd0;
      else if (w_g >= w_b)
         w_class = 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= c_ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:     if (i_start && !r_done) w_state_nxt = c_ST_SETTLE;
         c_ST_SETTLE:   if (w_settle_last) w_state_nxt = c_ST_GATE;
         c_ST_GATE:     if (w_gate_last)
                           w_state_nxt = (r_filt == c_F_CLEAR) ? c_ST_CLASSIFY : c_ST_SETTLE;
         c_ST_CLASSIFY: w_state_nxt = c_ST_EMIT;
         c_ST_EMIT:     if (i_out_ready)
                           w_state_nxt = w_last_sensor ? c_ST_IDLE : c_ST_SETTLE;
         default:       w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy       = (r_state != c_ST_IDLE);
      o_out_valid  = (r_state == c_ST_EMIT);
      o_sensor_sel = '0;
      o_color_sel  = 2'b00;
      if (r_state != c_ST_IDLE) begin
         o_sensor_sel = NUM_SENSORS'(1) << r_idx;
         case (r_filt)
            2'd0:    o_color_sel = 2'b00;
            2'd1:    o_color_sel = 2'b11;
            2'd2:    o_color_sel = 2'b01;
            default: o_color_sel = 2'b10;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmr       <= '0;
         r_filt      <= '0;
         r_idx       <= '0;
         r_sync      <= '0;
         r_prev      <= 1'b0;
         r_cnt       <= '0;
         for (int k = 0; k < 4; k++) r_meas[k] <= '0;
         r_color     <= '0;
         r_out_index <= '0;
         r_dark      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_freq_in};
         r_prev <= r_sync[1];
         r_done <= w_accept && w_last_sensor;

         if ((w_state_nxt != r_state) || (r_state != c_ST_SETTLE && r_state != c_ST_GATE))
            r_tmr <= '0;
         else
            r_tmr <= r_tmr + 1'b1;

         case (r_state)
            c_ST_IDLE: begin
               if (i_start && !r_done) begin
                  r_idx  <= '0;
                  r_filt <= '0;
               end
            end
            c_ST_SETTLE: r_cnt <= '0;
            c_ST_GATE: begin
               r_cnt <= w_cnt_nxt;
               // Latch includes an edge seen on the final gate cycle
               if (w_gate_last) begin
                  r_meas[r_filt] <= w_cnt_nxt;
                  if (r_filt != c_F_CLEAR) r_filt <= r_filt + 1'b1;
               end
            end
            c_ST_CLASSIFY: begin
               r_color     <= w_class;
               r_out_index <= r_idx;
               r_dark      <= (r_meas[3] < c_MIN_CLEAR);
            end
            c_ST_EMIT: begin
               if (i_out_ready) begin
                  r_filt <= '0;
                  r_idx  <= w_last_sensor ? '0 : r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_out_color = r_color;
   assign o_out_index = r_out_index;
   assign o_out_dark  = r_dark;
   assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_color_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_scan_engine
// Brief    : Bench for color_scan_engine with a scheduled behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_color_scan_engine;

   localparam int NS = 4;
   localparam int SW = 2;
   localparam int CW = 5;
   localparam int GC = 100;
   localparam int SC = 4;
   localparam int YS = 2;
   localparam int MC = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_freq_in = 1'b0;
   logic          i_out_ready = 1'b0;
   logic [NS-1:0] o_sensor_sel;
   logic [1:0]    o_color_sel;
   logic          o_out_valid;
   logic [1:0]    o_out_color;
   logic [SW-1:0] o_out_index;
   logic          o_out_dark;
   logic          o_busy;
   logic          o_done;

   always #5 clk = ~clk;

   color_scan_engine #(
      .NUM_SENSORS(NS), .SEL_W(SW), .COUNT_W(CW), .GATE_CYCLES(GC),
      .SETTLE_CYCLES(SC), .YEL_SHIFT(YS), .MIN_CLEAR(MC)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_freq_in(i_freq_in),
      .o_sensor_sel(o_sensor_sel), .o_color_sel(o_color_sel), .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready), .o_out_color(o_out_color), .o_out_index(o_out_index),
      .o_out_dark(o_out_dark), .o_busy(o_busy), .o_done(o_done)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Expected outputs for the current cycle
   logic [NS-1:0] e_sel   = '0;
   logic [1:0]    e_csel  = '0;
   logic          e_busy  = 1'b0;
   logic          e_valid = 1'b0;
   logic          e_done  = 1'b0;
   logic          e_rst   = 1'b1;
   logic [1:0]    e_color = '0;
   logic [SW-1:0] e_index = '0;
   logic          e_dark  = 1'b0;

   logic [1:0] csel_of [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

   int cfg_cnt   [NS][4];
   int cfg_lc    [NS];
   int cfg_ld    [NS];
   int cfg_stall [NS];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int n);
      return (n > CMAX) ? CMAX : n;
   endfunction

   function automatic logic [1:0] model_color(input int r_in, input int g_in, input int b_in);
      int v [3];
      int best;
      int mx;
      int d;
      v[0] = sat(r_in); v[1] = sat(g_in); v[2] = sat(b_in);
      mx = (v[0] > v[1]) ? v[0] : v[1];
      d  = (v[0] > v[1]) ? v[0] - v[1] : v[1] - v[0];
      if (v[0] > v[2] && v[1] > v[2] && d <= mx / (1 << YS)) return 2'd3;
      best = 0;
      for (int k = 1; k < 3; k++) if (v[k] > v[best]) best = k;
      return 2'(best);
   endfunction

   always @(negedge clk) begin
      chk("sensor_sel", o_sensor_sel, e_sel);
      chk("color_sel", o_color_sel, e_csel);
      chk("busy", o_busy, e_busy);
      chk("out_valid", o_out_valid, e_valid);
      chk("done", o_done, e_done);
      if (e_valid || e_rst) begin
         chk("out_color", o_out_color, e_color);
         chk("out_index", o_out_index, e_index);
         chk("out_dark", o_out_dark, e_dark);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_exp(input logic [NS-1:0] sel, input logic [1:0] csel,
                          input logic busy, input logic valid, input logic done);
      e_sel = sel; e_csel = csel; e_busy = busy; e_valid = valid; e_done = done; e_rst = 1'b0;
   endtask

   task automatic set_reset_exp();
      e_sel = '0; e_csel = '0; e_busy = 0; e_valid = 0; e_done = 0;
      e_color = '0; e_index = '0; e_dark = 0; e_rst = 1'b1;
   endtask

   // Runs one full scan from an idle cycle; optionally resets in sensor abort_s red gate
   task automatic scan(input int abort_s, input bit check_lat);
      int t_start;
      int n;
      logic rdy;
      set_exp('0, 2'b00, 0, 0, 0);
      i_start = 1'b1;
      i_out_ready = 1'b0;
      step();
      t_start = cyc;
      for (int s = 0; s < NS; s++) begin
         for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < SC; c++) begin
               set_exp(NS'(1) << s, csel_of[f], 1, 0, 0);
               i_freq_in = 1'b0;
               i_start = 1'($urandom_range(0, 1));
               step();
            end
            for (int c = 0; c < GC; c++) begin
               set_exp(NS'(1) << s, csel_of[f], 1, 0, 0);
               if (s == abort_s && f == 0 && c == 50) begin
                  rst_n = 1'b0;
                  #1;
                  chk("abort_sensor_sel", o_sensor_sel, 0);
                  chk("abort_busy", o_busy, 0);
                  chk("abort_valid", o_out_valid, 0);
                  set_reset_exp();
                  i_freq_in = 1'b0;
                  i_start = 1'b0;
                  step();
                  rst_n = 1'b1;
                  step();
                  return;
               end
               n = cfg_cnt[s][f];
               i_freq_in = (c >= 4 && c < 4 + 2 * n && ((c - 4) % 2 == 0));
               i_start = 1'b0;
               step();
            end
         end
         set_exp(NS'(1) << s, csel_of[3], 1, 0, 0);
         i_freq_in = 1'b0;
         i_out_ready = (cfg_stall[s] == 0);
         step();
         e_color = model_color(cfg_cnt[s][0], cfg_cnt[s][1], cfg_cnt[s][2]);
         e_index = SW'(s);
         e_dark  = (sat(cfg_cnt[s][3]) < MC);
         for (int k = 0; k <= cfg_stall[s]; k++) begin
            set_exp(NS'(1) << s, csel_of[3], 1, 1, 0);
            if (k == 0) begin
               if (check_lat && s == 0) chk("latency", cyc - t_start, 417);
               if (cfg_lc[s] >= 0) chk("literal_color", o_out_color, cfg_lc[s]);
               if (cfg_ld[s] >= 0) chk("literal_dark", o_out_dark, cfg_ld[s]);
            end
            rdy = (k >= cfg_stall[s]);
            i_out_ready = rdy;
            i_start = 1'($urandom_range(0, 1));
            step();
         end
         i_out_ready = 1'($urandom_range(0, 1)) & (s == NS - 1);
         i_start = 1'b0;
      end
      set_exp('0, 2'b00, 0, 0, 1);
      i_start = 1'b1;
      i_out_ready = 1'b0;
      step();
      set_exp('0, 2'b00, 0, 0, 0);
      i_start = 1'b0;
      step();
   endtask

   task automatic randomize_cfg();
      for (int s = 0; s < NS; s++) begin
         for (int f = 0; f < 4; f++) cfg_cnt[s][f] = $urandom_range(0, 45);
         cfg_lc[s] = -1;
         cfg_ld[s] = -1;
         cfg_stall[s] = $urandom_range(0, 3);
      end
   endtask

   initial begin
      set_reset_exp();
      rst_n = 1'b0;
      repeat (3) step();
      chk("reset_sensor_sel", o_sensor_sel, 0);
      chk("reset_out_color", o_out_color, 0);
      chk("reset_busy", o_busy, 0);
      rst_n = 1'b1;
      step();

      cfg_cnt   = '{'{20, 5, 2, 25}, '{24, 22, 3, 30}, '{24, 16, 3, 30}, '{10, 10, 10, 8}};
      cfg_lc    = '{0, 3, 0, 0};
      cfg_ld    = '{0, 0, 0, 1};
      cfg_stall = '{0, 1, 50, 0};
      scan(-1, 1'b1);

      cfg_cnt   = '{'{40, 31, 0, 45}, '{10, 30, 5, 20}, '{10, 10, 20, 20}, '{0, 0, 0, 0}};
      cfg_lc    = '{3, 1, 2, 0};
      cfg_ld    = '{0, 0, 0, 1};
      cfg_stall = '{0, 2, 0, 3};
      scan(-1, 1'b1);

      randomize_cfg();
      scan(1, 1'b0);

      for (int r = 0; r < 3; r++) begin
         randomize_cfg();
         scan(-1, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
